// File: rtl/pipe_ctrl_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_n_pkg
//  Purpose  : Shared encodings for the N-stage pipeline controller:
//             FSM state codes, redirect-cause codes and the STALL_ALL macro.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef STALL_ALL
`define STALL_ALL(n) {(n){1'b1}}
`endif

package pipe_ctrl_n_pkg;

    // FSM state codes
    localparam logic [0:0] ST_HOLD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        S_HOLD = ST_HOLD,
        S_RUN  = ST_RUN
    } state_e;

    // Redirect cause codes, in no particular priority order
    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_TRAP = 2'd1;
    localparam logic [1:0] CAUSE_JUMP = 2'd2;
    localparam logic [1:0] CAUSE_IRQ  = 2'd3;

    typedef logic [1:0] cause_t;

    // Trap and jump come from the redirect stage itself and squash older work;
    // an interrupt only ever fires on a fully idle pipe.
    function automatic logic is_ctl_redirect(input cause_t cause);
        return (cause == CAUSE_TRAP) || (cause == CAUSE_JUMP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_n_stall_vec_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_n_stall_vec_gen
//  Purpose  : Combinational stall/bubble vector generator. A stall request
//             from stage k holds every register at or before k; a bubble is
//             inserted into the first register that is free to advance.
//  Revision : 1.0  initial release
// ============================================================================

module pipe_ctrl_n_stall_vec_gen #(
    parameter int NUM_STAGES = 6
) (
    input  logic [NUM_STAGES-1:0] req_i,
    input  logic                  hold_all_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] bubble_o
);

    logic [NUM_STAGES-1:0] w_suffix;

    // Suffix-OR: register i holds if any stage at or after i requests a stall
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_suffix
        assign w_suffix[gi] = |req_i[NUM_STAGES-1:gi];
    end

    assign stall_o = hold_all_i ? `STALL_ALL(NUM_STAGES) : w_suffix;

    // A bubble goes where a held register feeds one that is moving
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_bubble
        if (gi == 0) begin : g_first
            assign bubble_o[gi] = 1'b0;
        end else begin : g_rest
            assign bubble_o[gi] = stall_o[gi-1] & ~stall_o[gi];
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_n.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_n
//  Purpose  : N-stage pipeline controller. Produces per-register stall and
//             bubble vectors, the PC redirect (trap > jump > interrupt),
//             a post-reset fetch hold, precise interrupt injection with EPC
//             capture, and a sticky stall watchdog.
//  Options  : PIPE_PERF_EN - enables the stall-cycle and flush performance
//             counters; without it the perf outputs are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================

module pipe_ctrl_n
    import pipe_ctrl_n_pkg::*;
#(
    parameter int NUM_STAGES     = 6,
    parameter int ADDR_WIDTH     = 32,
    parameter int REDIRECT_STAGE = 3,
    parameter int RESET_HOLD     = 2,
    parameter int STALL_TIMEOUT  = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic                  jump_enable_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  trap_req_i,
    input  logic [ADDR_WIDTH-1:0] trap_addr_i,
    input  logic                  irq_i,
    input  logic                  irq_en_i,
    input  logic [ADDR_WIDTH-1:0] irq_vec_i,
    input  logic [ADDR_WIDTH-1:0] exe_inst_addr_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic                  flush_o,
    output logic [ADDR_WIDTH-1:0] new_pc_o,
    output logic                  fetch_en_o,
    output logic                  irq_ack_o,
    output logic [ADDR_WIDTH-1:0] epc_o,
    output logic                  timeout_o,
    output logic [31:0]           perf_stall_cycles_o,
    output logic [31:0]           perf_flush_cnt_o
);

    localparam int                    c_wd_w       = $clog2(STALL_TIMEOUT + 1);
    localparam logic [c_wd_w-1:0]     c_wd_max     = c_wd_w'(STALL_TIMEOUT);
    localparam logic [3:0]            c_hold_last  = 4'(RESET_HOLD - 1);
    // Bits 0..REDIRECT_STAGE: registers at or before the redirect stage
    localparam logic [NUM_STAGES-1:0] c_older_mask =
        {NUM_STAGES{1'b1}} >> (NUM_STAGES - 1 - REDIRECT_STAGE);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [3:0]            r_hold_cnt;
    logic                  r_irq_pend;
    logic [ADDR_WIDTH-1:0] r_epc;
    logic [c_wd_w-1:0]     r_wd_cnt;
    logic                  r_timeout;

    logic                  w_run;
    logic                  w_younger_busy;
    cause_t                w_cause;
    logic [NUM_STAGES-1:0] w_req_eff;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_bubble;
    logic [ADDR_WIDTH-1:0] w_new_pc;

    assign w_run          = (r_state == S_RUN);
    assign w_younger_busy = |(stallreq_i & ~c_older_mask);

    // State register and reset-hold counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
            end
        end
    end

    // Next state: leave HOLD once the hold window has elapsed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HOLD:  if (r_hold_cnt == c_hold_last) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_HOLD;
        endcase
    end

    // Redirect arbitration: trap > jump > interrupt, only when nothing younger
    // than the redirect stage is stalled (the source re-asserts while held)
    always_comb begin
        w_cause  = CAUSE_NONE;
        w_new_pc = '0;
        if (w_run) begin
            if (!w_younger_busy && trap_req_i) begin
                w_cause = CAUSE_TRAP;
            end else if (!w_younger_busy && jump_enable_i) begin
                w_cause = CAUSE_JUMP;
            end else if (r_irq_pend && irq_en_i && (stallreq_i == '0)) begin
                w_cause = CAUSE_IRQ;
            end
        end
        case (w_cause)
            CAUSE_TRAP: w_new_pc = trap_addr_i;
            CAUSE_JUMP: w_new_pc = jump_addr_i;
            CAUSE_IRQ:  w_new_pc = irq_vec_i;
            default:    w_new_pc = '0;
        endcase
        // Older stages are being flushed, so their stall requests are moot
        w_req_eff = is_ctl_redirect(w_cause) ? (stallreq_i & ~c_older_mask) : stallreq_i;
    end

    pipe_ctrl_n_stall_vec_gen #(
        .NUM_STAGES (NUM_STAGES)
    ) u_stall_vec_gen (
        .req_i      (w_req_eff),
        .hold_all_i (!w_run),
        .stall_o    (w_stall),
        .bubble_o   (w_bubble)
    );

    // Pending interrupt latch and restart-PC capture on take
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq_pend <= 1'b0;
            r_epc      <= '0;
        end else begin
            r_irq_pend <= irq_i | (r_irq_pend & (w_cause != CAUSE_IRQ));
            if (w_cause == CAUSE_IRQ) begin
                r_epc <= exe_inst_addr_i;
            end
        end
    end

    // Stall watchdog: saturating run-length of fetch stalls, sticky flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_run) begin
            if (w_stall[0]) begin
                if (r_wd_cnt != c_wd_max) begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (r_wd_cnt == c_wd_max - 1'b1) begin
                        r_timeout <= 1'b1;
                    end
                end
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    assign stall_o    = w_stall;
    assign bubble_o   = w_bubble;
    assign flush_o    = (w_cause != CAUSE_NONE);
    assign new_pc_o   = w_new_pc;
    assign fetch_en_o = w_run;
    assign irq_ack_o  = (w_cause == CAUSE_IRQ);
    assign epc_o      = r_epc;
    assign timeout_o  = r_timeout;

`ifdef PIPE_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Free-running wrap-around performance counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_run && w_stall[0]) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_cause != CAUSE_NONE) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cycles_o = r_perf_stall;
    assign perf_flush_cnt_o    = r_perf_flush;
`else
    assign perf_stall_cycles_o = '0;
    assign perf_flush_cnt_o    = '0;
`endif

endmodule

`default_nettype wire
